// File: rtl/dff_bank_load_ctrl_pkg.sv
// Shared definitions for the serial-load flip-flop bank: controller state
// encodings and helpers for sizing and for building the preset word.
package dff_bank_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_PRESET = 2'd1;
    localparam state_t ST_LOAD   = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Widest bank the preset helper can describe.
    localparam int MAX_WIDTH = 256;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Word with the low 'width' bits set; callers size-cast it to their bank.
    function automatic logic [MAX_WIDTH-1:0] bank_all_ones(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_bank_load_ctrl_if.sv
// Bus between a serial configuration source (master) and the bank
// controller (slave): control requests, the serial beat handshake and the
// parallel word and status seen by downstream logic.
interface dff_bank_load_ctrl_if
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int IDX_W = idx_width(WIDTH);

    logic             start;
    logic             pre_req;
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] q;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, pre_req, sin, sin_valid,
        input  sin_ready, q, bit_idx, busy, done
    );

    modport slave (
        input  start, pre_req, sin, sin_valid,
        output sin_ready, q, bit_idx, busy, done
    );

endinterface

// File: rtl/dff_bank_load_ctrl_bit_counter.sv
// Index of the next bank bit to be written. Clear has priority over
// increment, and an increment at the last bit returns to zero rather than
// running past the end of the bank.
module bank_bit_counter
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    assign at_last = (idx == LAST_IDX);

    // Bit index register: clear, step, or hold.
    // NOTE: reset sits in the sensitivity list so the index clears the moment
    // rst_n falls, with no clock required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr || (inc && at_last)) begin
            // NOTE: non-blocking assignment keeps every register reading the
            // pre-edge value of every other register, whatever the block order.
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/dff_bank_load_ctrl.sv
// Controller and storage for a bank of preset-able flip-flops. A word is
// shifted in one bit per accepted valid/ready beat (LSB first, via per-bit
// write enables), or the whole bank is forced to ones by a preset request,
// which also aborts a load in progress.
module dff_bank_load_ctrl
    import dff_bank_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int PRESET_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    dff_bank_load_ctrl_if.slave bus
);

    localparam int               IDX_W    = idx_width(WIDTH);
    localparam int               PC_W     = idx_width(PRESET_CYCLES);
    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(bank_all_ones(WIDTH));
    localparam logic [PC_W-1:0]  PC_LOAD  = PC_W'(PRESET_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pre_cnt;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            at_last;
    logic            accept;
    logic            enter_preset;

    // A preset request refuses the beat in the same cycle it is raised.
    assign bus.sin_ready = (state == ST_LOAD) && !bus.pre_req;
    assign accept        = bus.sin_valid && bus.sin_ready;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

    // Entering PRESET from IDLE or LOAD is what loads the bank with ones.
    assign enter_preset  = (state_nxt == ST_PRESET) && (state != ST_PRESET);

    bank_bit_counter #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .idx     (bus.bit_idx),
        .at_last (at_last)
    );

    // Next-state and bit-counter control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.pre_req) begin
                    state_nxt = ST_PRESET;
                end else if (bus.start) begin
                    state_nxt = ST_LOAD;
                    cnt_clr   = 1'b1;
                end
            end
            ST_PRESET: begin
                if (pre_cnt == '0) state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                if (bus.pre_req) begin
                    state_nxt = ST_PRESET;
                    cnt_clr   = 1'b1;
                end else if (accept) begin
                    cnt_inc = 1'b1;
                    if (at_last) begin
                        state_nxt = ST_DONE;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Bank flops: all ones on entry to preset, else a single-bit write per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.q <= '0;
        end else if (enter_preset) begin
            bus.q <= ALL_ONES;
        end else if (accept) begin
            bus.q[bus.bit_idx] <= bus.sin;
        end
    end

    // Preset dwell counter: loaded on entry, counts down to the exit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (enter_preset) begin
            pre_cnt <= PC_LOAD;
        end else if ((state == ST_PRESET) && (pre_cnt != '0)) begin
            pre_cnt <= pre_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_dff_bank_load_ctrl.sv
// Directed bench for dff_bank_load_ctrl (WIDTH=8, PRESET_CYCLES=2).
// Each vector is one clock: inputs driven on the falling edge, sin_ready
// checked before the rising edge, registered outputs checked just after it.
module tb_dff_bank_load_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dff_bank_load_ctrl_if #(.WIDTH(W)) bus ();

    dff_bank_load_ctrl #(
        .WIDTH         (W),
        .PRESET_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       start;
        logic       pre_req;
        logic       sin;
        logic       sin_valid;
        logic       exp_ready;
        logic [7:0] exp_q;
        logic [2:0] exp_idx;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic add(input string name, input logic st, input logic pr,
                       input logic s, input logic sv, input logic rdy,
                       input logic [7:0] q, input logic [2:0] idx,
                       input logic b, input logic d);
        vec_t v;
        v.name = name; v.start = st; v.pre_req = pr; v.sin = s; v.sin_valid = sv;
        v.exp_ready = rdy; v.exp_q = q; v.exp_idx = idx; v.exp_busy = b; v.exp_done = d;
        vecs.push_back(v);
    endtask

    // Full load of 'word' from bank value q0, optionally stalling stall_len
    // cycles before the beat that writes bit stall_at.
    task automatic add_load(input string name, input logic [7:0] q0, input logic [7:0] word,
                            input int stall_at, input int stall_len);
        logic [7:0] q;
        q = q0;
        add({name, " start"}, 1, 0, 0, 0, 0, q, 3'd0, 1, 0);
        for (int b = 0; b < 8; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++)
                    add($sformatf("%s stall%0d", name, s), 0, 0, 1, 0, 1, q, 3'(b), 1, 0);
            end
            q[b] = word[b];
            add($sformatf("%s beat%0d", name, b), 0, 0, word[b], 1, 1, q,
                3'((b + 1) % 8), 1, (b == 7));
        end
        add({name, " after_done"}, 0, 0, 0, 0, 0, q, 3'd0, 0, 0);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.start     = v.start;
        bus.pre_req   = v.pre_req;
        bus.sin       = v.sin;
        bus.sin_valid = v.sin_valid;
        #1;
        check({v.name, " sin_ready"}, 32'(bus.sin_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        check({v.name, " q"},       32'(bus.q),       32'(v.exp_q));
        check({v.name, " bit_idx"}, 32'(bus.bit_idx), 32'(v.exp_idx));
        check({v.name, " busy"},    32'(bus.busy),    32'(v.exp_busy));
        check({v.name, " done"},    32'(bus.done),    32'(v.exp_done));
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    task automatic check_reset_state(input string name);
        check({name, " q"},         32'(bus.q),         32'h00);
        check({name, " bit_idx"},   32'(bus.bit_idx),   32'h0);
        check({name, " busy"},      32'(bus.busy),      32'h0);
        check({name, " done"},      32'(bus.done),      32'h0);
        check({name, " sin_ready"}, 32'(bus.sin_ready), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.pre_req   = 1'b0;
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back load of A5 from a cleared bank, then clear it again.
        add_load("t1_a5", 8'h00, 8'hA5, -1, 0);
        add_load("clr0", 8'hA5, 8'h00, -1, 0);

        // Preset from IDLE; START during PRESET must be ignored.
        add("t2 pre_req", 0, 1, 0, 0, 0, 8'hFF, 3'd0, 1, 0);
        add("t2 start_in_preset1", 1, 0, 0, 0, 0, 8'hFF, 3'd0, 1, 0);
        add("t2 start_in_preset2", 1, 0, 0, 0, 0, 8'hFF, 3'd0, 0, 0);
        add("t2 idle", 0, 0, 0, 0, 0, 8'hFF, 3'd0, 0, 0);

        // START and PRE_REQ together: preset wins, so no ready follows.
        add("t5 both", 1, 1, 0, 0, 0, 8'hFF, 3'd0, 1, 0);
        add("t5 preset2", 0, 0, 1, 1, 0, 8'hFF, 3'd0, 1, 0);
        add("t5 idle", 0, 0, 1, 1, 0, 8'hFF, 3'd0, 0, 0);

        // Load 3C with a five-cycle stall before bit 3.
        add_load("t3_3c", 8'hFF, 8'h3C, 3, 5);
        add_load("clr0b", 8'h3C, 8'h00, -1, 0);

        // Three ones, then a preset abort with a beat on offer.
        add("t4 start", 1, 0, 0, 0, 0, 8'h00, 3'd0, 1, 0);
        add("t4 beat0", 0, 0, 1, 1, 1, 8'h01, 3'd1, 1, 0);
        add("t4 beat1", 0, 0, 1, 1, 1, 8'h03, 3'd2, 1, 0);
        add("t4 beat2", 0, 0, 1, 1, 1, 8'h07, 3'd3, 1, 0);
        add("t4 abort", 0, 1, 0, 1, 0, 8'hFF, 3'd0, 1, 0);
        add("t4 preset2", 0, 0, 0, 0, 0, 8'hFF, 3'd0, 1, 0);
        add("t4 idle", 0, 0, 0, 0, 0, 8'hFF, 3'd0, 0, 0);

        // Start a load that reset will interrupt.
        add("t6 start", 1, 0, 0, 0, 0, 8'hFF, 3'd0, 1, 0);
        add("t6 beat0", 0, 0, 0, 1, 1, 8'hFE, 3'd1, 1, 0);
        add("t6 beat1", 0, 0, 1, 1, 1, 8'hFE, 3'd2, 1, 0);
        run_vecs();

        // Asynchronous reset between edges, with a beat on offer.
        @(negedge clk);
        bus.start     = 1'b0;
        bus.pre_req   = 1'b0;
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b1;
        #1;
        check("t6 pre_reset sin_ready", 32'(bus.sin_ready), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("t6 async_reset");
        @(posedge clk);
        #1;
        check_reset_state("t6 held_reset");
        @(negedge clk);
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b0;
        rst_n         = 1'b1;

        add_load("t6_81", 8'h00, 8'h81, -1, 0);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
